// File: rtl/fifo_line_scheduler_if.sv
// Handshake bundle between the pixel FIFO read port, the line scheduler and the LED driver.
//   fifo_empty/fifo_aempty/fifo_do : FIFO status and show-ahead head word
//   fifo_re                        : pop strobe from the scheduler
//   m_valid/m_ready/m_data         : pixel stream towards the driver
//   m_sol/m_eol                    : first/last pixel of a line marks
// master = scheduler side, slave = FIFO + driver side.
interface fifo_line_scheduler_if #(
  parameter int unsigned DW = 12
);
  logic          fifo_empty;
  logic          fifo_aempty;
  logic [DW-1:0] fifo_do;
  logic          fifo_re;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sol;
  logic          m_eol;

  modport master (
    input  fifo_empty, fifo_aempty, fifo_do, m_ready,
    output fifo_re, m_valid, m_data, m_sol, m_eol
  );

  modport slave (
    output fifo_empty, fifo_aempty, fifo_do, m_ready,
    input  fifo_re, m_valid, m_data, m_sol, m_eol
  );
endinterface

// File: rtl/fifo_line_scheduler.sv
// Read-side sequencer for the show-ahead LED pixel FIFO. Waits for the FIFO to pass
// almost-empty, drains one line of LINE_LEN pixels into a valid/ready stream with
// start/end-of-line marks, inserts GAP_CYC blanking cycles between lines and aborts a
// line when the FIFO stays empty for TIMEOUT output-free cycles.
// Ports:
//   clk, rst_n   : FIFO read clock, asynchronous active-low reset
//   en_i         : schedule lines (sampled in FILL and at GAP exit)
//   bus          : FIFO read port + pixel stream (master modport)
//   underrun_o   : one-cycle pulse on line abort
//   line_cnt_o   : completed lines, wraps
//   busy_o       : scheduler not in IDLE
module fifo_line_scheduler #(
  parameter int unsigned DW       = 12,
  parameter int unsigned LINE_LEN = 64,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  fifo_line_scheduler_if.master bus,
  output logic                  underrun_o,
  output logic [15:0]           line_cnt_o,
  output logic                  busy_o
);

  localparam int unsigned PW = $clog2(LINE_LEN);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    BURST = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0]   line_q, line_d;
  logic          underrun_q, underrun_d;
  logic          busy_q, busy_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          sol_q, sol_d;
  logic          eol_q, eol_d;
  logic          out_free;
  logic          pop;
  logic          last_pix;

  // Output register can take a word when empty or being drained this cycle.
  assign out_free = ~m_valid_q | bus.m_ready;
  assign pop      = (state_q == BURST) & ~bus.fifo_empty & out_free;
  assign last_pix = (pix_q == PW'(LINE_LEN - 1));

  // Next-state, counters and output register.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    gap_d      = gap_q;
    stall_d    = stall_q;
    line_d     = line_q;
    underrun_d = 1'b0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    sol_d      = sol_q;
    eol_d      = eol_q;

    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.fifo_do;
      sol_d     = (pix_q == '0);
      eol_d     = last_pix;
    end else if (m_valid_q & bus.m_ready) begin
      m_valid_d = 1'b0;
      sol_d     = 1'b0;
      eol_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (en_i) state_d = FILL;
      end
      FILL: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (!bus.fifo_aempty) begin
          state_d = BURST;
          pix_d   = '0;
          stall_d = '0;
        end
      end
      BURST: begin
        if (pop) begin
          stall_d = '0;
          if (last_pix) begin
            pix_d   = '0;
            state_d = DRAIN;
          end else begin
            pix_d = pix_q + PW'(1);
          end
        end else if (bus.fifo_empty & out_free) begin
          // Backpressure alone never advances the stall timer.
          if (stall_q == SW'(TIMEOUT - 1)) begin
            underrun_d = 1'b1;
            pix_d      = '0;
            stall_d    = '0;
            gap_d      = '0;
            state_d    = GAP;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      DRAIN: begin
        if (m_valid_q & bus.m_ready) begin
          line_d  = line_q + 16'd1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = en_i ? FILL : IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      gap_q      <= '0;
      stall_q    <= '0;
      line_q     <= '0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      gap_q      <= gap_d;
      stall_q    <= stall_d;
      line_q     <= line_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      sol_q      <= sol_d;
      eol_q      <= eol_d;
    end
  end

  assign bus.fifo_re = pop;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sol   = sol_q;
  assign bus.m_eol   = eol_q;
  assign underrun_o  = underrun_q;
  assign line_cnt_o  = line_q;
  assign busy_o      = busy_q;

endmodule
